// File: rtl/decimal_req_arbiter_pkg.sv
// Shared definitions for the decimal request arbiter.
// Holds the default parameter values and the FSM state encoding used by
// decimal_req_arbiter and its testbench.
package decimal_req_arbiter_pkg;

    localparam int N_REQ_DEF    = 10;
    localparam int ID_W_DEF     = 4;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/onehot10_bin4_enc.sv
// One-hot to binary encoder, 10 inputs to a 4-bit index.
// Ports:
//   onehot : 10-bit one-hot (or all-zero) input
//   bin    : bit position of the set input bit, 0 when the input is zero
module onehot10_bin4_enc (
    input  logic [9:0] onehot,
    output logic [3:0] bin
);

    // OR together the indices of all set bits; for a one-hot input this is
    // exactly the position of the set bit, and zero input yields zero.
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (onehot[i]) begin
                bin = bin | 4'(i);
            end
        end
    end

endmodule

// File: rtl/decimal_req_arbiter.sv
// Round-robin arbiter for ten requesters with a bounded grant tenure.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   req       : per-requester request levels
//   gnt       : registered one-hot grant
//   gnt_id    : binary index of the granted requester (0 when idle)
//   gnt_valid : high when gnt is non-zero
//   hold_cnt  : grant cycles already spent in the current tenure
module decimal_req_arbiter
    import decimal_req_arbiter_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  hold_cnt
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic [ID_W-1:0]    sel_id;
    logic               sel_found;
    int unsigned        scan_idx;
    logic               owner_req;
    logic               hold_last;

    onehot10_bin4_enc u_enc (
        .onehot (gnt_q),
        .bin    (gnt_id)
    );

    // Round-robin scan: first set request at or above ptr, wrapping.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = (32'(ptr_q) + i) % N_REQ;
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(scan_idx);
            end
        end
    end

    // The owner is still requesting iff its grant bit overlaps req.
    assign owner_req = |(req & gnt_q);
    assign hold_last = (hold_cnt_q == ID_W'(MAX_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (sel_found) begin
                    state_d        = GRANT;
                    gnt_d          = '0;
                    gnt_d[sel_id]  = 1'b1;
                end
            end
            GRANT: begin
                // A dropped request and the hold limit coinciding give one exit.
                if (!owner_req || hold_last) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                    ptr_d      = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_decimal_req_arbiter.sv
// Self-checking bench for decimal_req_arbiter: directed scenarios followed by
// randomized traffic, all compared against a tenure-level reference model.
module tb_decimal_req_arbiter;

    localparam int N  = 10;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [3:0]   gnt_id;
    logic         gnt_valid;
    logic [3:0]   hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the channel, how long they've had it, and
    // where the next search starts.
    int m_owner = -1;
    int m_used  = 0;
    int m_ptr   = 0;

    decimal_req_arbiter #(.N_REQ(N), .ID_W(4), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [N-1:0] q);
        if (r) begin
            m_owner = -1; m_used = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (q[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_used  = 1;
                    break;
                end
            end
        end else if (!q[m_owner] || m_used == MH) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_used  = 0;
        end else begin
            m_used++;
        end
    endtask

    task automatic step(input logic [N-1:0] q, input logic r);
        logic [N-1:0] exp_gnt;
        int           dec_id;
        int           ones;
        req = q;
        rst = r;
        @(posedge clk);
        #1;
        model_edge(r, q);
        exp_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_id_model", 32'(gnt_id), (m_owner < 0) ? 0 : m_owner);
        check("hold_cnt", 32'(hold_cnt), (m_owner < 0) ? 0 : m_used - 1);
        ones = 0; dec_id = 0;
        for (int k = 0; k < N; k++) if (gnt[k]) begin ones++; dec_id = k; end
        check("onehot", 32'(ones <= 1), 1);
        check("gnt_id_dec", 32'(gnt_id), dec_id);
        check("gnt_valid", 32'(gnt_valid), 32'(ones != 0));
    endtask

    initial begin
        // Reset
        step('0, 1'b1);
        step('0, 1'b1);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_valid", 32'(gnt_valid), 0);

        // Single requester, drop after three grant cycles
        step(10'b0000000100, 1'b0);
        check("s1_gnt", 32'(gnt), 32'h004);
        check("s1_id", 32'(gnt_id), 2);
        check("s1_valid", 32'(gnt_valid), 1);
        step(10'b0000000100, 1'b0);
        step(10'b0000000100, 1'b0);
        check("s1_hold", 32'(hold_cnt), 2);
        step('0, 1'b0);
        check("s1_drop_gnt", 32'(gnt), 0);
        check("s1_drop_hold", 32'(hold_cnt), 0);

        // Idle for 20 cycles
        for (int c = 0; c < 20; c++) begin
            step('0, 1'b0);
            check("idle_gnt", 32'(gnt), 0);
            check("idle_id", 32'(gnt_id), 0);
            check("idle_valid", 32'(gnt_valid), 0);
        end

        // All requesting: 0..9,0, each MH cycles plus one dead cycle
        step('0, 1'b1);
        for (int t = 0; t < 11; t++) begin
            for (int c = 0; c < MH; c++) begin
                step(10'h3FF, 1'b0);
                check("rr_id", 32'(gnt_id), t % N);
                check("rr_valid", 32'(gnt_valid), 1);
                check("rr_hold", 32'(hold_cnt), c);
            end
            step(10'h3FF, 1'b0);
            check("rr_dead", 32'(gnt), 0);
        end

        // Wrap: ptr left at 9 after granting 8
        step('0, 1'b1);
        step(10'b0100000000, 1'b0);
        check("wrap_pre", 32'(gnt_id), 8);
        step('0, 1'b0);
        step(10'b1000000001, 1'b0);
        check("wrap_id9", 32'(gnt_id), 9);
        for (int c = 1; c < MH; c++) step(10'b1000000001, 1'b0);
        step(10'b1000000001, 1'b0);
        check("wrap_dead", 32'(gnt), 0);
        step(10'b1000000001, 1'b0);
        check("wrap_id0", 32'(gnt_id), 0);

        // Reset in the middle of a tenure of id 5
        step('0, 1'b1);
        step(10'b0000100000, 1'b0);
        step(10'b0000100000, 1'b0);
        step(10'b0000100000, 1'b0);
        check("mid_hold", 32'(hold_cnt), 2);
        step(10'b0000100000, 1'b1);
        check("mid_rst_gnt", 32'(gnt), 0);
        check("mid_rst_hold", 32'(hold_cnt), 0);
        step(10'b0000100000, 1'b0);
        check("mid_regrant", 32'(gnt_id), 5);
        check("mid_regrant_hold", 32'(hold_cnt), 0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] q;
            q = N'($urandom) & N'($urandom) & N'($urandom_range(0, 1) ? 10'h3FF : 10'h0F0);
            step(q, ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
